muldiv_unit: RTL

Parametrised iterative multiply/divide unit for the multi-cycle ARM core. It takes over the UMUL, SMUL and DIV ALU operations from the single-cycle ALU and adds signed divide. It computes full double-width products and quotient/remainder pairs over WIDTH cycles behind a Start/Busy/Done handshake. The controller holds its execute state while Busy is high and writes results back on Done.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_absneg.sv | 12 +
 rtl/muldiv_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encoding, FSM states and ALUControl mapping for muldiv_unit
package muldiv_pkg;

  localparam logic [1:0] MD_UMUL = 2'b00;
  localparam logic [1:0] MD_SMUL = 2'b01;
  localparam logic [1:0] MD_UDIV = 2'b10;
  localparam logic [1:0] MD_SDIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_t;

  // ALUControl mul/div codes of the core; anything else falls back to UMUL.
  function automatic logic [1:0] alu_to_op(input logic [3:0] alu_control);
    case (alu_control)
      4'b1000: return MD_UMUL;
      4'b1001: return MD_SMUL;
      4'b1010: return MD_UDIV;
      4'b1011: return MD_SDIV;
      default: return MD_UMUL;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// rtl/muldiv_absneg.sv - conditional two's-complement negate
module muldiv_absneg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide with Start/Busy/Done handshake
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t        state;
  logic [1:0]       op_q;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]    count;

  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign a_neg_in = Op[0] & SrcA[WIDTH-1];
  assign b_neg_in = Op[0] & SrcB[WIDTH-1];

  muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (.a(SrcA), .neg(a_neg_in), .y(a_mag));
  muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (.a(SrcB), .neg(b_neg_in), .y(b_mag));

  // acc = {hi, lo}: lo starts as multiplier / dividend and is shifted out as hi fills.
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};

  always_comb begin
    acc_step = acc;
    if (op_q[1]) begin
      if (!diff[WIDTH])
        acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_step = {sum, acc[WIDTH-1:1]};
      else
        acc_step = acc >> 1;
    end
  end

  // Sign fix is applied to the final step's value so write-back lands on the last CALC edge.
  muldiv_absneg #(.WIDTH(2*WIDTH)) u_fix_prod (.a(acc_step), .neg(neg_res), .y(prod_fixed));
  muldiv_absneg #(.WIDTH(WIDTH)) u_fix_quo (.a(acc_step[WIDTH-1:0]), .neg(neg_res), .y(quo_fixed));
  muldiv_absneg #(.WIDTH(WIDTH)) u_fix_rem (.a(acc_step[2*WIDTH-1:WIDTH]), .neg(neg_rem), .y(rem_fixed));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      b_q       <= '0;
      acc       <= '0;
      count     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ResultLo  <= '0;
      ResultHi  <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q      <= Op;
            neg_res   <= a_neg_in ^ b_neg_in;
            neg_rem   <= a_neg_in;
            b_q       <= b_mag;
            acc       <= {{WIDTH{1'b0}}, a_mag};
            count     <= '0;
            DivByZero <= 1'b0;
            if (Op[1] && (SrcB == '0)) begin
              ResultLo  <= '1;
              ResultHi  <= SrcA;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= DONE;
            end else begin
              Busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (count == LAST) begin
            if (op_q[1]) begin
              ResultLo <= quo_fixed;
              ResultHi <= rem_fixed;
            end else begin
              ResultLo <= prod_fixed[WIDTH-1:0];
              ResultHi <= prod_fixed[2*WIDTH-1:WIDTH];
            end
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
